// File: rtl/qc_pkg.sv
// qc_pkg: shared types and constants for the quantum-state UART loader
package qc_pkg;
  localparam int Q = 6;
  localparam int N = 8;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } complexNum;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} ld_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with input synchronizer and start-bit glitch rejection
module uart_rx
  import qc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  rx_state_t st, nxt;
  logic [1:0] sync;
  logic line, prev;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic tick_half, tick_full;
  assign line = sync[1];
  assign tick_half = cnt == HALF_M1;
  assign tick_full = cnt == FULL_M1;
  // two-stage synchronizer plus delayed copy for falling-edge detection; idles high
  always_ff @(posedge clk or posedge reset)
    if (reset) {sync, prev} <= 3'b111;
    else {sync, prev} <= {sync[0], rx, line};
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= RX_IDLE;
    else st <= nxt;
  // next state: start edge, mid-start check, eight data bits, stop bit
  always_comb begin
    nxt = st;
    case (st)
      RX_IDLE:  nxt = (prev && !line) ? RX_START : RX_IDLE;
      RX_START: nxt = tick_half ? (line ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  nxt = (tick_full && bit_idx == 3'd7) ? RX_STOP : RX_DATA;
      RX_STOP:  nxt = tick_full ? RX_IDLE : RX_STOP;
      default:  nxt = RX_IDLE;
    endcase
  end
  // bit timer, shift register and one-cycle result pulses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cnt        <= (st == RX_IDLE || st != nxt || (st == RX_DATA && tick_full)) ? '0 : cnt + 1'b1;
      bit_idx    <= (st == RX_START) ? '0 : (st == RX_DATA && tick_full) ? bit_idx + 1'b1 : bit_idx;
      data       <= (st == RX_DATA && tick_full) ? {line, data[7:1]} : data;
      byte_valid <= st == RX_STOP && tick_full && line;
      frame_err  <= st == RX_STOP && tick_full && !line;
    end
endmodule

// File: rtl/uart_state_loader.sv
// uart_state_loader: receives checksummed frames of complex amplitudes over UART and commits them atomically
module uart_state_loader
  import qc_pkg::*;
#(
  parameter int         N_STATES     = 2,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RsRx,
  output logic [N_STATES*8-1:0] state_a,
  output logic [N_STATES*8-1:0] state_b,
  output logic                  load_done,
  output logic                  chk_err,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int NB = 2 * N_STATES;
  localparam int IW = $clog2(NB + 1);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
  ld_state_t st, nxt;
  logic [7:0] data, chk;
  logic byte_valid;
  logic [IW-1:0] idx;
  complexNum shadow [N_STATES];
  logic start, take, commit, bad;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (RsRx),
    .data      (data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );
  assign start  = byte_valid && st == IDLE && data == HEADER;
  assign take   = byte_valid && st == PAYLOAD;
  assign commit = byte_valid && st == CHECK && data == chk;
  assign bad    = byte_valid && st == CHECK && data != chk;
  // state register; busy follows the state that is being entered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st   <= IDLE;
      busy <= 1'b0;
    end else begin
      st   <= nxt;
      busy <= nxt != IDLE;
    end
  // next state: a receive framing error always abandons the frame
  always_comb begin
    nxt = st;
    if (frame_err) nxt = IDLE;
    else if (byte_valid)
      case (st)
        IDLE:    nxt = (data == HEADER) ? PAYLOAD : IDLE;
        PAYLOAD: nxt = (idx == LAST) ? CHECK : PAYLOAD;
        CHECK:   nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  // payload collects into shadow; outputs copy from shadow only on a good checksum
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx       <= '0;
      chk       <= '0;
      state_a   <= '0;
      state_b   <= '0;
      load_done <= 1'b0;
      chk_err   <= 1'b0;
      for (int i = 0; i < N_STATES; i++) shadow[i] <= '0;
    end else begin
      load_done <= commit;
      chk_err   <= bad;
      if (start) begin
        idx <= '0;
        chk <= '0;
      end
      if (take) begin
        idx <= idx + 1'b1;
        chk <= chk ^ data;
        for (int i = 0; i < N_STATES; i++) begin
          if (idx == IW'(2 * i)) shadow[i].a <= data;
          if (idx == IW'(2 * i + 1)) shadow[i].b <= data;
        end
      end
      if (commit)
        for (int i = 0; i < N_STATES; i++) begin
          state_a[8*i +: 8] <= shadow[i].a;
          state_b[8*i +: 8] <= shadow[i].b;
        end
    end
endmodule

// File: tb/tb_uart_state_loader.sv
// tb_uart_state_loader: scoreboard bench for the UART state loader
module tb_uart_state_loader;
  localparam int CPB = 16;
  logic clk = 1'b0, reset = 1'b1, RsRx = 1'b1;
  logic [15:0] state_a, state_b;
  logic load_done, chk_err, frame_err, busy;
  int vectors = 0, errors = 0, done_cnt = 0, chk_cnt = 0, fe_cnt = 0, bv_cnt = 0;
  logic [31:0] exp_q [$];
  logic [15:0] model_a = '0, model_b = '0;

  uart_state_loader #(.N_STATES(2), .CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .RsRx(RsRx), .state_a(state_a), .state_b(state_b),
    .load_done(load_done), .chk_err(chk_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // monitor: counts pulses and checks each commit against the scoreboard
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (dut.u_rx.byte_valid) bv_cnt++;
    if (chk_err) chk_cnt++;
    if (frame_err) fe_cnt++;
    if (load_done) begin
      done_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit: unexpected load_done a=%h b=%h", state_a, state_b);
      end else begin
        e = exp_q.pop_front();
        if ({state_a, state_b} !== e) begin
          errors++;
          $display("FAIL commit: got a=%h b=%h want a=%h b=%h", state_a, state_b, e[31:16], e[15:0]);
        end
        model_a = e[31:16];
        model_b = e[15:0];
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RsRx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      repeat (CPB) @(posedge clk);
    end
    RsRx = stop;
    repeat (CPB) @(posedge clk);
    RsRx = 1'b1;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int k = 5; k >= 0; k--) send_byte(f[8*k +: 8], 1'b1);
  endtask

  task automatic settle_and_check(input string name, input int d_exp, input int c_exp);
    repeat (20) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (done_cnt !== d_exp) begin errors++; $display("FAIL %s load_done count: got %0d want %0d", name, done_cnt, d_exp); end
    vectors++;
    if (chk_cnt !== c_exp) begin errors++; $display("FAIL %s chk_err count: got %0d want %0d", name, chk_cnt, c_exp); end
    vectors++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL %s pending commits: got %0d want 0", name, exp_q.size()); exp_q.delete(); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy idle: got %b want 0", name, busy); end
    vectors++;
    if ({state_a, state_b} !== {model_a, model_b}) begin
      errors++;
      $display("FAIL %s outputs: got %h/%h want %h/%h", name, state_a, state_b, model_a, model_b);
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({state_a, state_b} !== 32'h0) begin errors++; $display("FAIL reset outputs: got %h want 0", {state_a, state_b}); end
    vectors++;
    if ({busy, load_done, chk_err, frame_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset flags: got %b want 0000", {busy, load_done, chk_err, frame_err});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_load;
    int d0 = done_cnt, c0 = chk_cnt;
    exp_q.push_back({16'h3010, 16'h4020});
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL load busy after header: got %b want 1", busy); end
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h40, 1'b1);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL load busy in check: got %b want 1", busy); end
    vectors++;
    if (state_a !== 16'h0) begin errors++; $display("FAIL load partial frame visible: got %h want 0000", state_a); end
    send_byte(8'h40, 1'b1);
    settle_and_check("load", d0 + 1, c0);
  endtask

  task automatic test_chk_err;
    int d0 = done_cnt, c0 = chk_cnt;
    send_frame(48'hA5_01_02_03_04_41);
    settle_and_check("chk_err", d0, c0 + 1);
  endtask

  task automatic test_header_as_data;
    int d0 = done_cnt, c0 = chk_cnt, b0 = bv_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    exp_q.push_back({16'hA5A5, 16'hA5A5});
    send_frame(48'hA5_A5_A5_A5_A5_00);
    settle_and_check("header_data", d0 + 1, c0);
    vectors++;
    if (bv_cnt !== b0 + 8) begin errors++; $display("FAIL header_data byte count: got %0d want %0d", bv_cnt, b0 + 8); end
  endtask

  task automatic test_frame_err;
    int d0 = done_cnt, c0 = chk_cnt, f0 = fe_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b0);
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (fe_cnt !== f0 + 1) begin errors++; $display("FAIL frame_err pulses: got %0d want %0d", fe_cnt, f0 + 1); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL frame_err busy: got %b want 0", busy); end
    exp_q.push_back({16'h3311, 16'h4422});
    send_frame(48'hA5_11_22_33_44_44);
    settle_and_check("frame_err_recover", d0 + 1, c0);
  endtask

  task automatic test_glitch;
    int b0 = bv_cnt, f0 = fe_cnt;
    @(posedge clk);
    RsRx = 1'b0;
    repeat (4) @(posedge clk);
    RsRx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bv_cnt !== b0) begin errors++; $display("FAIL glitch byte_valid: got %0d want %0d", bv_cnt, b0); end
    vectors++;
    if (fe_cnt !== f0) begin errors++; $display("FAIL glitch frame_err: got %0d want %0d", fe_cnt, f0); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    int d0, c0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    RsRx = 1'b0;
    repeat (CPB * 3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    vectors++;
    if ({state_a, state_b} !== 32'h0) begin errors++; $display("FAIL async reset outputs: got %h want 0", {state_a, state_b}); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL async reset busy: got %b want 0", busy); end
    model_a = '0;
    model_b = '0;
    repeat (3) @(posedge clk);
    RsRx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    d0 = done_cnt;
    c0 = chk_cnt;
    exp_q.push_back({16'h3010, 16'h4020});
    send_frame(48'hA5_10_20_30_40_40);
    settle_and_check("reset_recover", d0 + 1, c0);
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt, c0 = chk_cnt;
    exp_q.push_back({16'h0301, 16'h0402});
    exp_q.push_back({16'h0FAA, 16'hF055});
    send_frame(48'hA5_01_02_03_04_04);
    send_frame(48'hA5_AA_55_0F_F0_00);
    settle_and_check("back_to_back", d0 + 2, c0);
  endtask

  initial begin
    test_reset;
    test_load;
    test_chk_err;
    test_header_as_data;
    test_frame_err;
    test_glitch;
    test_reset_mid_frame;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
